// File: rtl/genius_controller_if.sv
// Control/status bundle between the Genius controller FSM and its datapath.
// master = controller side, slave = datapath side.
interface genius_controller_if;
  logic       enter;
  logic       end_FPGA;
  logic       end_User;
  logic       end_time;
  logic       win;
  logic       match;
  logic       R1;
  logic       R2;
  logic       E1;
  logic       E2;
  logic       E3;
  logic       E4;
  logic       SEL;
  logic [2:0] state_o;

  modport master (
    input  enter, end_FPGA, end_User, end_time, win, match,
    output R1, R2, E1, E2, E3, E4, SEL, state_o
  );

  modport slave (
    output enter, end_FPGA, end_User, end_time, win, match,
    input  R1, R2, E1, E2, E3, E4, SEL, state_o
  );
endinterface

// File: rtl/genius_controller.sv
// Moore control FSM for the Genius memory game; drives datapath resets/enables.
// Optional macro GENIUS_TIMEOUT_EN: end_time in PLAY ends the game (loss by timeout).
module genius_controller #(
  parameter int unsigned PAUSE_CYCLES = 25_000_000,
  parameter int unsigned PAUSE_W      = 25
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  genius_controller_if.master bus
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    SETUP   = 3'd1,
    SEQ     = 3'd2,
    PLAY    = 3'd3,
    CHECK   = 3'd4,
    NEXT    = 3'd5,
    RESULT  = 3'd6,
    ILLEGAL = 3'd7
  } state_e;

  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 enter_q;
  logic [PAUSE_W-1:0]   pause_q, pause_d;
  logic                 enter_rise;
  logic                 timeout;

  assign enter_rise = bus.enter & ~enter_q;

`ifdef GENIUS_TIMEOUT_EN
  assign timeout = bus.end_time;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= INIT;
      enter_q <= 1'b0;
      pause_q <= '0;
    end else begin
      state_q <= state_d;
      enter_q <= bus.enter;
      pause_q <= pause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pause_d = '0;
    case (state_q)
      INIT:   state_d = SETUP;
      SETUP:  if (enter_rise) state_d = SEQ;
      SEQ:    if (bus.end_FPGA) state_d = PLAY;
      // end_User has priority over a simultaneous time-out
      PLAY: begin
        if (bus.end_User)  state_d = CHECK;
        else if (timeout)  state_d = RESULT;
      end
      CHECK:  state_d = (bus.match && !bus.win) ? NEXT : RESULT;
      NEXT: begin
        if (pause_q == PAUSE_LAST) begin
          state_d = SEQ;
        end else begin
          pause_d = pause_q + 1'b1;
        end
      end
      RESULT: if (enter_rise) state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    bus.R1      = 1'b0;
    bus.R2      = 1'b0;
    bus.E1      = 1'b0;
    bus.E2      = 1'b0;
    bus.E3      = 1'b0;
    bus.E4      = 1'b0;
    bus.SEL     = 1'b1;
    bus.state_o = state_q;
    case (state_q)
      SETUP:  bus.E1 = 1'b1;
      SEQ:    bus.E3 = 1'b1;
      PLAY:   bus.E2 = 1'b1;
      CHECK:  ;
      // round advance pulses only on the first pause cycle
      NEXT: begin
        bus.E4 = (pause_q == '0);
        bus.R2 = (pause_q == '0);
      end
      RESULT: bus.SEL = 1'b0;
      default: begin
        bus.R1 = 1'b1;
        bus.R2 = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_genius_controller.sv
// Directed scoreboard bench for genius_controller with a 4-cycle pause.
module tb_genius_controller;

  localparam int S_INIT = 0, S_SETUP = 1, S_SEQ = 2, S_PLAY = 3,
                 S_CHECK = 4, S_NEXT = 5, S_RESULT = 6;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   last_exp = -1;

  typedef struct {
    logic [9:0] vec;
    string      tag;
  } exp_t;

  exp_t sb[$];

  genius_controller_if bus ();

  genius_controller #(.PAUSE_CYCLES(4), .PAUSE_W(3)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Expected {state, R1, R2, E1, E2, E3, E4, SEL} straight from the state table.
  function automatic logic [9:0] expect_vec(int st, bit first_next);
    logic r1, r2, e1, e2, e3, e4, sel;
    r1 = 0; r2 = 0; e1 = 0; e2 = 0; e3 = 0; e4 = 0; sel = 1;
    case (st)
      S_INIT:   begin r1 = 1; r2 = 1; end
      S_SETUP:  e1 = 1;
      S_SEQ:    e3 = 1;
      S_PLAY:   e2 = 1;
      S_NEXT:   begin e4 = first_next; r2 = first_next; end
      S_RESULT: sel = 0;
      default:  ;
    endcase
    return {3'(st), r1, r2, e1, e2, e3, e4, sel};
  endfunction

  task automatic step(input logic r, input logic en, input logic fp, input logic us,
                      input logic tm, input logic w, input logic m,
                      input int exp_st, input string tag);
    exp_t e;
    logic [9:0] obs;
    rst = r; bus.enter = en; bus.end_FPGA = fp; bus.end_User = us;
    bus.end_time = tm; bus.win = w; bus.match = m;
    e.vec = expect_vec(exp_st, (exp_st == S_NEXT) && (last_exp != S_NEXT));
    e.tag = tag;
    sb.push_back(e);
    last_exp = exp_st;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    obs = {bus.state_o, bus.R1, bus.R2, bus.E1, bus.E2, bus.E3, bus.E4, bus.SEL};
    checks++;
    assert (obs === e.vec) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
    end
  endtask

  initial begin
    rst = 1; bus.enter = 0; bus.end_FPGA = 0; bus.end_User = 0;
    bus.end_time = 0; bus.win = 0; bus.match = 0;
    // power-on reset
    step(1, 0, 0, 0, 0, 0, 0, S_INIT,  "reset0");
    step(1, 0, 0, 0, 0, 0, 0, S_INIT,  "reset1");
    step(0, 0, 0, 0, 0, 0, 0, S_SETUP, "init_to_setup");
    step(0, 0, 0, 0, 0, 0, 0, S_SETUP, "setup_wait");
    step(0, 1, 0, 0, 0, 0, 0, S_SEQ,   "enter_to_seq");
    step(0, 0, 0, 0, 0, 0, 0, S_SEQ,   "seq_wait");
    step(0, 0, 1, 0, 0, 0, 0, S_PLAY,  "fpga_to_play");
    step(0, 0, 0, 0, 0, 0, 0, S_PLAY,  "play_wait");
    // end_User and end_time together: end_User wins
    step(0, 0, 0, 1, 1, 0, 1, S_CHECK, "both_to_check");
    step(0, 0, 0, 0, 0, 0, 1, S_NEXT,  "match_to_next");
    for (int i = 1; i < 4; i++)
      step(0, 0, 0, 0, 0, 0, 0, S_NEXT, $sformatf("pause%0d", i));
    step(0, 0, 0, 0, 0, 0, 0, S_SEQ,   "pause_to_seq");
    step(0, 0, 1, 0, 0, 0, 0, S_PLAY,  "round2_play");
`ifdef GENIUS_TIMEOUT_EN
    step(0, 0, 0, 0, 1, 0, 0, S_RESULT, "timeout_result");
`else
    step(0, 0, 0, 0, 1, 0, 0, S_PLAY,   "timeout_ignored");
    step(0, 0, 0, 1, 0, 0, 0, S_CHECK,  "mismatch_check");
    step(0, 0, 0, 0, 0, 0, 0, S_RESULT, "mismatch_result");
`endif
    step(0, 0, 0, 0, 0, 0, 0, S_RESULT, "result_wait");
    // held button across RESULT->INIT->SETUP gives one edge only
    step(0, 1, 0, 0, 0, 0, 0, S_INIT,  "result_to_init");
    step(0, 1, 0, 0, 0, 0, 0, S_SETUP, "held_setup0");
    for (int i = 1; i < 4; i++)
      step(0, 1, 0, 0, 0, 0, 0, S_SETUP, $sformatf("held_setup%0d", i));
    step(0, 0, 0, 0, 0, 0, 0, S_SETUP, "release_setup");
    step(0, 1, 0, 0, 0, 0, 0, S_SEQ,   "repress_seq");
    for (int i = 1; i < 10; i++)
      step(0, 1, 0, 0, 0, 0, 0, S_SEQ, $sformatf("held_seq%0d", i));
    step(0, 0, 1, 0, 0, 0, 0, S_PLAY,  "win_play");
    step(0, 0, 0, 1, 0, 1, 1, S_CHECK, "win_check");
    step(0, 0, 0, 0, 0, 1, 1, S_RESULT, "win_result");
    step(0, 1, 0, 0, 0, 0, 0, S_INIT,  "win_to_init");
    step(0, 0, 0, 0, 0, 0, 0, S_SETUP, "win_setup");
    step(0, 1, 0, 0, 0, 0, 0, S_SEQ,   "r_seq");
    step(0, 0, 1, 0, 0, 0, 0, S_PLAY,  "r_play");
    // mid-operation reset from PLAY
    step(1, 1, 0, 0, 0, 0, 0, S_INIT,  "midreset0");
    step(1, 1, 0, 0, 0, 0, 0, S_INIT,  "midreset1");
    step(0, 0, 0, 0, 0, 0, 0, S_SETUP, "after_reset");
    step(0, 1, 0, 0, 0, 0, 0, S_SEQ,   "after_reset_seq");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
